// File: rtl/hdmi_seq_pkg.sv
// Shared types and constants for the HDMI mode-change sequencer.
package hdmi_seq_pkg;

    localparam int unsigned MODE_W  = 8;
    localparam int unsigned RETRY_W = 4;

    typedef logic [MODE_W-1:0] mode_t;

    // 1080p-class default, matches entry 0 of reconf_rom
    localparam mode_t DEFAULT_MODE = 8'h00;

    typedef enum logic [3:0] {
        WAIT_LOCK,
        SETTLE,
        ADV_RESTART,
        WAIT_ADV,
        RUN,
        BLANK,
        RECONF,
        WAIT_UNLOCK,
        FAIL
    } seq_state_e;

endpackage

// File: rtl/hdmi_mode_sequencer_lock_sync.sv
// Two-flop synchroniser bringing pll_locked into the hdmi_clock domain.
module lock_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/hdmi_mode_sequencer.sv
// Owns the HDMI mode-change ordering: blank, PLL reconf, relock, settle, ADV restart, run.
// HDMI_SEQ_LOCKLOSS_RECOVERY_EN: re-run the boot path on PLL lock loss while running.
module hdmi_mode_sequencer
    import hdmi_seq_pkg::*;
#(
    parameter int unsigned BLANK_CYCLES   = 16,
    parameter int unsigned UNLOCK_TIMEOUT = 4096,
    parameter int unsigned LOCK_TIMEOUT   = 1048576,
    parameter int unsigned LOCK_STABLE    = 256,
    parameter int unsigned SETTLE_CYCLES  = 65536,
    parameter int unsigned ADV_TIMEOUT    = 1048576,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned CNT_W          = 24
) (
    input  logic  clock_i,
    input  logic  reset_i,
    input  logic  req_valid_i,
    input  mode_t req_mode_i,
    output logic  req_ready_o,
    input  logic  pll_locked_i,
    output logic  reconf_strobe_o,
    output mode_t reconf_data_o,
    output logic  adv_restart_o,
    input  logic  adv_ready_i,
    output logic  video_enable_o,
    output logic  busy_o,
    output logic  done_o,
    output logic  fail_o,
    output mode_t current_mode_o,
    output logic  lockloss_seen_o
);

    seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   stab_q, stab_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    mode_t              target_q, target_d;
    logic               lock_s;
    logic               accept_c;
    logic               same_mode_c;

    lock_sync u_lock_sync (
        .clk_i   (clock_i),
        .rst_i   (reset_i),
        .async_i (pll_locked_i),
        .sync_o  (lock_s)
    );

    assign accept_c    = req_valid_i && req_ready_o;
    assign same_mode_c = (req_mode_i == current_mode_o);

    // Next-state, retry and timer logic
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        retry_d  = retry_q;

        unique case (state_q)
            BLANK: begin
                if (cnt_q >= CNT_W'(BLANK_CYCLES - 1)) state_d = RECONF;
            end
            RECONF: state_d = WAIT_UNLOCK;
            WAIT_UNLOCK: begin
                // Timeout still proceeds: the PLL may relock faster than we can see the drop
                if (!lock_s || cnt_q >= CNT_W'(UNLOCK_TIMEOUT - 1)) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s && stab_q >= CNT_W'(LOCK_STABLE - 1)) begin
                    state_d = SETTLE;
                end else if (cnt_q >= CNT_W'(LOCK_TIMEOUT - 1)) begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = (32'(retry_q) >= MAX_RETRIES) ? FAIL : RECONF;
                end
            end
            SETTLE: begin
                if (cnt_q >= CNT_W'(SETTLE_CYCLES - 1)) state_d = ADV_RESTART;
            end
            ADV_RESTART: state_d = WAIT_ADV;
            WAIT_ADV: begin
                if (adv_ready_i) begin
                    state_d = RUN;
                end else if (cnt_q >= CNT_W'(ADV_TIMEOUT - 1)) begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = (32'(retry_q) >= MAX_RETRIES) ? FAIL : ADV_RESTART;
                end
            end
            RUN: begin
                if (accept_c) begin
                    retry_d = '0;
                    if (!same_mode_c) begin
                        target_d = req_mode_i;
                        state_d  = BLANK;
                    end
`ifdef HDMI_SEQ_LOCKLOSS_RECOVERY_EN
                end else if (!lock_s) begin
                    target_d = current_mode_o;
                    state_d  = WAIT_LOCK;
`endif
                end
            end
            FAIL: begin
                if (accept_c) begin
                    retry_d  = '0;
                    target_d = req_mode_i;
                    state_d  = BLANK;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase

        if (state_d == RUN) retry_d = '0;

        cnt_d = (state_d != state_q) ? '0 : ((&cnt_q) ? cnt_q : cnt_q + CNT_W'(1));

        stab_d = '0;
        if (state_q == WAIT_LOCK && state_d == WAIT_LOCK && lock_s)
            stab_d = (&stab_q) ? stab_q : stab_q + CNT_W'(1);
    end

    // State and registered outputs, decoded from the upcoming state
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q         <= WAIT_LOCK;
            cnt_q           <= '0;
            stab_q          <= '0;
            retry_q         <= '0;
            target_q        <= DEFAULT_MODE;
            req_ready_o     <= 1'b0;
            reconf_strobe_o <= 1'b0;
            reconf_data_o   <= '0;
            adv_restart_o   <= 1'b0;
            video_enable_o  <= 1'b0;
            busy_o          <= 1'b1;
            done_o          <= 1'b0;
            fail_o          <= 1'b0;
            current_mode_o  <= DEFAULT_MODE;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            stab_q          <= stab_d;
            retry_q         <= retry_d;
            target_q        <= target_d;
            req_ready_o     <= (state_d == RUN || state_d == FAIL) && !accept_c;
            reconf_strobe_o <= (state_d == RECONF);
            reconf_data_o   <= (state_d == RECONF) ? target_d : '0;
            adv_restart_o   <= (state_d == ADV_RESTART);
            video_enable_o  <= (state_d == RUN);
            busy_o          <= !(state_d == RUN || state_d == FAIL);
            done_o          <= (state_d == RUN) && (state_q != RUN || accept_c);
            fail_o          <= (state_d == FAIL);
            if (state_d == RUN && state_q != RUN) current_mode_o <= target_d;
        end
    end

`ifdef HDMI_SEQ_LOCKLOSS_RECOVERY_EN
    assign lockloss_seen_o = 1'b0;
`else
    logic lockloss_q;

    // Status only: a lock drop while running is recorded until the next request
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i)                            lockloss_q <= 1'b0;
        else if (accept_c)                      lockloss_q <= 1'b0;
        else if (state_q == RUN && !lock_s)     lockloss_q <= 1'b1;
    end

    assign lockloss_seen_o = lockloss_q;
`endif

endmodule

// File: tb/tb_hdmi_mode_sequencer.sv
// Self-checking bench for hdmi_mode_sequencer (honours HDMI_SEQ_LOCKLOSS_RECOVERY_EN).
module tb_hdmi_mode_sequencer;

    localparam int T_BLANK  = 4;
    localparam int T_UTO    = 32;
    localparam int T_LTO    = 100;
    localparam int T_STABLE = 8;
    localparam int T_SETTLE = 16;
    localparam int T_ATO    = 64;
    localparam int T_RETRY  = 2;
    // sync delay + stable window + settle, from a locked input to adv_restart
    localparam int BOOT_LAT = 2 + T_STABLE + T_SETTLE;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [7:0] req_mode;
    logic       req_ready_o;
    logic       pll_locked;
    logic       reconf_strobe_o;
    logic [7:0] reconf_data_o;
    logic       adv_restart_o;
    logic       adv_ready;
    logic       video_enable_o;
    logic       busy_o;
    logic       done_o;
    logic       fail_o;
    logic [7:0] current_mode_o;
    logic       lockloss_seen_o;

    always #5 clk = ~clk;

    hdmi_mode_sequencer #(
        .BLANK_CYCLES   (T_BLANK),
        .UNLOCK_TIMEOUT (T_UTO),
        .LOCK_TIMEOUT   (T_LTO),
        .LOCK_STABLE    (T_STABLE),
        .SETTLE_CYCLES  (T_SETTLE),
        .ADV_TIMEOUT    (T_ATO),
        .MAX_RETRIES    (T_RETRY),
        .CNT_W          (24)
    ) dut (
        .clock_i         (clk),
        .reset_i         (reset),
        .req_valid_i     (req_valid),
        .req_mode_i      (req_mode),
        .req_ready_o     (req_ready_o),
        .pll_locked_i    (pll_locked),
        .reconf_strobe_o (reconf_strobe_o),
        .reconf_data_o   (reconf_data_o),
        .adv_restart_o   (adv_restart_o),
        .adv_ready_i     (adv_ready),
        .video_enable_o  (video_enable_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .fail_o          (fail_o),
        .current_mode_o  (current_mode_o),
        .lockloss_seen_o (lockloss_seen_o)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_strobe = 0;
    int         n_restart = 0;
    int         n_done   = 0;
    int         adv_cnt  = 0;
    int         adv_delay = 10;
    logic [7:0] model_mode = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: count output events and play the ADV7513 (ready N cycles after restart)
    task automatic tick();
        @(negedge clk);
        if (reconf_strobe_o) n_strobe++;
        if (done_o)          n_done++;
        if (adv_restart_o) begin
            n_restart++;
            adv_ready = 1'b0;
            adv_cnt   = adv_delay;
        end else if (adv_cnt > 0) begin
            adv_cnt--;
            if (adv_cnt == 0) adv_ready = 1'b1;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // sel: 0 strobe, 1 adv_restart, 2 done, 3 fail; n = cycles waited or -1
    task automatic wait_sig(input int sel, input int budget, output int n);
        logic hit;
        hit = 1'b0;
        n   = 0;
        while (!hit && n < budget) begin
            tick();
            n++;
            case (sel)
                0:       hit = reconf_strobe_o;
                1:       hit = adv_restart_o;
                2:       hit = done_o;
                default: hit = fail_o;
            endcase
        end
        if (!hit) n = -1;
    endtask

    task automatic do_request(input logic [7:0] m, output int n);
        n         = 0;
        req_valid = 1'b1;
        req_mode  = m;
        while (!req_ready_o && n < 3000) begin
            tick();
            n++;
        end
        tick();
        req_valid = 1'b0;
        if (n >= 3000) n = -1;
    endtask

    function automatic logic [7:0] pick(input logic [7:0] avoid);
        logic [7:0] v;
        v = 8'($urandom_range(1, 255));
        while (v == avoid) v = 8'($urandom_range(1, 255));
        return v;
    endfunction

    // Full mode change with the PLL dropping lock for lock_low cycles after reconf
    task automatic change_mode(input logic [7:0] m, input int lock_low);
        int n, s0, r0, d0;
        s0 = n_strobe; r0 = n_restart; d0 = n_done;
        adv_delay = $urandom_range(1, 20);
        do_request(m, n);
        check("accept_seen", 32'(n >= 0), 1);
        check("accept_video", 32'(video_enable_o), 0);
        check("accept_busy", 32'(busy_o), 1);
        check("accept_ready", 32'(req_ready_o), 0);
        check("accept_fail", 32'(fail_o), 0);
        check("accept_lockloss", 32'(lockloss_seen_o), 0);
        wait_sig(0, 50, n);
        check("blank_len", n, T_BLANK);
        check("strobe_data", 32'(reconf_data_o), 32'(m));
        pll_locked = 1'b0;
        ticks(lock_low);
        pll_locked = 1'b1;
        wait_sig(2, 3000, n);
        check("run_seen", 32'(n > 0), 1);
        check("run_mode", 32'(current_mode_o), 32'(m));
        check("run_video", 32'(video_enable_o), 1);
        check("run_busy", 32'(busy_o), 0);
        check("run_strobes", n_strobe - s0, 1);
        check("run_restarts", n_restart - r0, 1);
        check("run_dones", n_done - d0, 1);
        model_mode = m;
    endtask

    initial begin
        int n, s0, r0, d0;
        logic [7:0] m;

        reset = 1'b1; req_valid = 1'b0; req_mode = 8'h00;
        pll_locked = 1'b1; adv_ready = 1'b0;
        ticks(2);
        check("rst_video", 32'(video_enable_o), 0);
        check("rst_busy", 32'(busy_o), 1);
        check("rst_ready", 32'(req_ready_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_fail", 32'(fail_o), 0);
        check("rst_strobe", 32'(reconf_strobe_o), 0);
        check("rst_data", 32'(reconf_data_o), 0);
        check("rst_restart", 32'(adv_restart_o), 0);
        check("rst_mode", 32'(current_mode_o), 0);

        // Boot: PLL locked throughout, ADV ready 10 cycles after restart
        reset = 1'b0;
        adv_delay = 10;
        wait_sig(1, 200, n);
        check("boot_restart_lat", n, BOOT_LAT);
        wait_sig(2, 200, n);
        check("boot_done_lat", n, 11);
        ticks(3);
        check("boot_restarts", n_restart, 1);
        check("boot_strobes", n_strobe, 0);
        check("boot_dones", n_done, 1);
        check("boot_video", 32'(video_enable_o), 1);
        check("boot_mode", 32'(current_mode_o), 0);
        check("boot_ready", 32'(req_ready_o), 1);

        change_mode(8'h03, 50);

        // Lock chatter during WAIT_LOCK: no locked run reaches the stable window
        m = pick(model_mode);
        s0 = n_strobe; r0 = n_restart;
        do_request(m, n);
        wait_sig(0, 50, n);
        check("chatter_blank", n, T_BLANK);
        pll_locked = 1'b0;
        ticks(5);
        for (int p = 0; p < 4; p++) begin
            pll_locked = 1'b1;
            ticks($urandom_range(1, T_STABLE - 1));
            pll_locked = 1'b0;
            ticks($urandom_range(1, 5));
        end
        check("chatter_no_restart", n_restart - r0, 0);
        check("chatter_busy", 32'(busy_o), 1);
        pll_locked = 1'b1;
        wait_sig(1, 200, n);
        check("chatter_relock_lat", n, BOOT_LAT);
        wait_sig(2, 200, n);
        check("chatter_run_mode", 32'(current_mode_o), 32'(m));
        check("chatter_strobes", n_strobe - s0, 1);
        model_mode = m;

        // Same-mode request: immediate done, no blanking, no reconf
        s0 = n_strobe; d0 = n_done;
        do_request(model_mode, n);
        check("same_done", 32'(done_o), 1);
        check("same_video", 32'(video_enable_o), 1);
        check("same_busy", 32'(busy_o), 0);
        ticks(T_BLANK + 4);
        check("same_strobes", n_strobe - s0, 0);
        check("same_dones", n_done - d0, 1);
        check("same_video_hold", 32'(video_enable_o), 1);

        // Lock loss while running
        s0 = n_strobe; d0 = n_done;
        pll_locked = 1'b0;
`ifdef HDMI_SEQ_LOCKLOSS_RECOVERY_EN
        ticks(4);
        check("ll_video", 32'(video_enable_o), 0);
        check("ll_busy", 32'(busy_o), 1);
        check("ll_ready", 32'(req_ready_o), 0);
        pll_locked = 1'b1;
        wait_sig(2, 500, n);
        check("ll_redone", 32'(n > 0), 1);
        check("ll_strobes", n_strobe - s0, 0);
        check("ll_dones", n_done - d0, 1);
        check("ll_mode", 32'(current_mode_o), 32'(model_mode));
        check("ll_status", 32'(lockloss_seen_o), 0);
`else
        ticks(6);
        check("ll_status", 32'(lockloss_seen_o), 1);
        check("ll_video", 32'(video_enable_o), 1);
        check("ll_busy", 32'(busy_o), 0);
        pll_locked = 1'b1;
        ticks(4);
        check("ll_status_sticky", 32'(lockloss_seen_o), 1);
        check("ll_dones", n_done - d0, 0);
`endif

        for (int i = 0; i < 3; i++) change_mode(pick(model_mode), $urandom_range(1, 40));

        // Permanent unlock: initial reconf plus T_RETRY retries, then FAIL
        m = pick(model_mode);
        s0 = n_strobe; d0 = n_done;
        do_request(m, n);
        wait_sig(0, 50, n);
        check("fail_blank", n, T_BLANK);
        pll_locked = 1'b0;
        wait_sig(0, 400, n);
        check("retry1_seen", 32'(n > 0), 1);
        check("retry1_data", 32'(reconf_data_o), 32'(m));
        wait_sig(0, 400, n);
        check("retry2_gap", n, T_LTO + 2);
        check("retry2_data", 32'(reconf_data_o), 32'(m));
        wait_sig(3, 400, n);
        check("fail_gap", n, T_LTO + 2);
        check("fail_strobes", n_strobe - s0, T_RETRY + 1);
        check("fail_flag", 32'(fail_o), 1);
        check("fail_ready", 32'(req_ready_o), 1);
        check("fail_busy", 32'(busy_o), 0);
        check("fail_video", 32'(video_enable_o), 0);
        check("fail_mode", 32'(current_mode_o), 32'(model_mode));
        check("fail_dones", n_done - d0, 0);
        ticks(20);
        check("fail_sticky", 32'(fail_o), 1);

        change_mode(pick(model_mode), 20);

        // Asynchronous reset in the middle of SETTLE
        m = pick(model_mode);
        do_request(m, n);
        wait_sig(0, 50, n);
        pll_locked = 1'b0;
        ticks(10);
        pll_locked = 1'b1;
        r0 = n_restart;
        ticks(2 + T_STABLE + T_SETTLE / 2);
        check("mid_settle_busy", 32'(busy_o), 1);
        check("mid_settle_no_restart", n_restart - r0, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_mode", 32'(current_mode_o), 0);
        check("arst_video", 32'(video_enable_o), 0);
        check("arst_busy", 32'(busy_o), 1);
        check("arst_ready", 32'(req_ready_o), 0);
        check("arst_fail", 32'(fail_o), 0);
        check("arst_done", 32'(done_o), 0);
        ticks(3);
        reset = 1'b0;
        s0 = n_strobe; r0 = n_restart;
        wait_sig(1, 200, n);
        check("reboot_restart_lat", n, BOOT_LAT);
        wait_sig(2, 200, n);
        check("reboot_done", 32'(n > 0), 1);
        check("reboot_strobes", n_strobe - s0, 0);
        check("reboot_restarts", n_restart - r0, 1);
        check("reboot_mode", 32'(current_mode_o), 0);
        check("reboot_video", 32'(video_enable_o), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hdmi_mode_sequencer.md
Name: hdmi_mode_sequencer

Overview:
Sequences an HDMI output mode change in the hdmi_clock domain.
- On an accepted request it blanks the ram2video output, requests a pll_hdmi reconfiguration through the reconf byte path, waits for PLL relock and settle, restarts the ADV7513 and waits for its ready, then re-enables video.
- Replaces the ad-hoc ordering between trigger_reconf, the startup delays and the ram2video reset gating with one owner of that sequence.

Parameters:
- BLANK_CYCLES, 16: cycles output stays blanked before reconf is issued.
- UNLOCK_TIMEOUT, 4096: max cycles to observe PLL unlock after reconf.
- LOCK_TIMEOUT, 1048576: max cycles to reach stable lock.
- LOCK_STABLE, 256: consecutive locked cycles required.
- SETTLE_CYCLES, 65536: delay after lock before ADV restart.
- ADV_TIMEOUT, 1048576: max cycles waiting for adv_ready.
- MAX_RETRIES, 3: retries before FAIL; counter is shared across PLL and ADV timeouts.
- CNT_W, 24: timer width; must hold the largest timeout.

Ports:
- clock  in  1  hdmi_clock
- reset  in  1  asynchronous, active-high
- req_valid  in  1  mode change request
- req_mode  in  8  requested mode code (reconf byte)
- req_ready  out  1  request accepted when valid&&ready at edge
- pll_locked  in  1  pll_hdmi locked, asynchronous; synchronised internally
- reconf_strobe  out  1  one-cycle write toward reconf FIFO path
- reconf_data  out  8  mode byte, valid with strobe
- adv_restart  out  1  one-cycle ADV7513 restart pulse
- adv_ready  in  1  ADV7513 configured
- video_enable  out  1  gates ram2video reset; 1 = video running
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse on entering RUN
- fail  out  1  sticky while in FAIL
- current_mode  out  8  last successfully applied mode

Behaviour:
- All outputs registered.
- Reset values: video_enable=0, reconf_strobe=0, reconf_data=0, adv_restart=0, req_ready=0, done=0, fail=0, busy=1, current_mode=DEFAULT_MODE.
- While reset is asserted the state is held at WAIT_LOCK and the retry count is 0.
- After reset release the block runs the boot path: WAIT_LOCK -> SETTLE -> ADV_RESTART -> WAIT_ADV -> RUN. No reconf is issued on boot.
- States:
  - IDLE is not used; RUN and FAIL are the resting states.
  - BLANK: video_enable=0; counts BLANK_CYCLES.
  - RECONF: one cycle; reconf_strobe=1, reconf_data=target.
  - WAIT_UNLOCK: exits on synchronised lock=0. On timeout, goes to WAIT_LOCK anyway (fast relock case).
  - WAIT_LOCK: requires LOCK_STABLE consecutive locked cycles; any unlock restarts the stable count. On LOCK_TIMEOUT: retry++, go to RECONF, or FAIL once retry exceeds MAX_RETRIES.
  - SETTLE: counts SETTLE_CYCLES.
  - ADV_RESTART: one cycle; adv_restart=1.
  - WAIT_ADV: exits on adv_ready=1. On ADV_TIMEOUT: retry++, go to ADV_RESTART, or FAIL.
  - RUN: video_enable=1, current_mode=target, done pulses once, retry cleared.
- req_ready=1 only in RUN and FAIL, and 0 on the cycle of acceptance.
- Acceptance in RUN or FAIL latches target=req_mode, clears retry and fail, and goes to BLANK. The first cycle after acceptance has video_enable=0 and busy=1.
- A request for the same mode in RUN is accepted with no sequence: done pulses on the next cycle and video_enable stays 1.
- In FAIL: video_enable=0, busy=0, fail=1. Only a new request or reset leaves FAIL.
- Timer width: timers saturate, never wrap. Comparisons are >= PARAM-1 on an equal-width compare.
- req_valid during busy is ignored (not queued). Requesters hold req_valid until accepted.
- adv_ready dropping in RUN is ignored, since ADV7513 handles its own hotplug.

Optional Feature:
- Macro: HDMI_SEQ_LOCKLOSS_RECOVERY_EN.
- Defined: in RUN, synchronised lock=0 immediately drops video_enable and enters WAIT_LOCK with target=current_mode, then re-runs the boot path and pulses done again.
  - req_ready stays 0 during recovery.
- Undefined: lock loss in RUN is ignored except for the lockloss_seen status bit. This bit sets on lock=0 in RUN and clears on the next accepted request. The port exists in both builds and is tied 0 when the macro is defined.

Decomposition:
- Shared package hdmi_seq_pkg holds:
  - the state enum typedef (WAIT_LOCK, SETTLE, ADV_RESTART, WAIT_ADV, RUN, BLANK, RECONF, WAIT_UNLOCK, FAIL);
  - the 8-bit mode typedef;
  - DEFAULT_MODE constant 8'h00 (1080p-class default used by reconf_rom);
  - the retry counter width constant.
- One sub-module, lock_sync: a 2-flop synchroniser with async active-high reset to 0, for pll_locked.

Test Plan:
- Boot with test parameters (BLANK=4, LOCK_STABLE=8, SETTLE=16). Hold pll_locked=1 and raise adv_ready 10 cycles after adv_restart -> exactly one adv_restart, no reconf_strobe, done pulse once, video_enable=1, current_mode=8'h00.
- In RUN, request req_mode=8'h03. Drop pll_locked for 50 cycles after the strobe -> video_enable=0 the next cycle, reconf_strobe with data 8'h03 after 4 blank cycles, RUN reached with current_mode=8'h03.
- Keep pll_locked=0 after reconf with LOCK_TIMEOUT=100, MAX_RETRIES=2 -> 3 reconf_strobes total, then FAIL, fail=1, req_ready=1, busy=0.
- Toggle pll_locked every 5 cycles during WAIT_LOCK -> stable count restarts and the state does not advance until 8 consecutive locked cycles.
- Request the same mode 8'h03 in RUN -> no strobe, no blanking, done one cycle later.
- Assert reset mid-SETTLE -> all outputs return to reset values asynchronously and the boot path reruns. With HDMI_SEQ_LOCKLOSS_RECOVERY_EN defined, lock loss in RUN produces a second done with no reconf_strobe.
